// File: rtl/uart_acia.sv
// uart_acia: 6551-style ACIA. Four CPU-visible registers, 8N1 serial TX/RX,
// active-low interrupt. Bit timing comes from two independent phase
// accumulators; the CONTROL register is plain storage.
//
// Bus handshake: one access per rising clk edge with cs=1. rw=1 is a read
// and rw=0 is a write. There is no wait state. data_out is a combinational
// mux on {rs1,rs0} and is meaningful whenever cs=1. A read of register 00
// clears its flags at the access edge, so the bus sees the pre-clear value.
module uart_acia #(
   parameter int unsigned clk_freq_hz = 27_000_000,
   parameter int unsigned baud_rate   = 115200,
   parameter int unsigned oversample  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rw,
   input  logic       rs0,
   input  logic       rs1,
   input  logic       cs,
   input  logic [7:0] data_in,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       tx,
   output logic       irq
);
   // oversample has no timing effect; it cancels out of the increment.
   localparam logic [31:0] CLK_HZ   = 32'(clk_freq_hz);
   localparam logic [31:0] BAUD_INC = 32'(baud_rate * (oversample / oversample));

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic [1:0]  sel;
   logic        wr_tdr, wr_preset, wr_cmd, wr_ctrl, rd_rdr;

   tx_state_t   tx_state, tx_next;
   logic [31:0] tx_acc, tx_sum;
   logic        tx_tick, tx_load, tdre;
   logic [2:0]  tx_cnt;
   logic [7:0]  tx_shift, tx_hold;

   rx_state_t   rx_state, rx_next;
   logic [31:0] rx_acc, rx_sum;
   logic        rx_tick, rx_done, rx_meta, rx_s;
   logic [2:0]  rx_cnt;
   logic [7:0]  rx_shift;

   logic        rdrf, ovr, fe, irq_pend;
   logic [7:0]  rx_data, cmd, ctrl, status;

   // Bus decode: one strobe per register side effect.
   always_comb begin
      sel       = {rs1, rs0};
      wr_tdr    = cs && !rw && (sel == 2'b00);
      wr_preset = cs && !rw && (sel == 2'b01);
      wr_cmd    = cs && !rw && (sel == 2'b10);
      wr_ctrl   = cs && !rw && (sel == 2'b11);
      rd_rdr    = cs &&  rw && (sel == 2'b00);
   end

   // TX next state, baud tick and serial output.
   always_comb begin
      tx_sum  = tx_acc + BAUD_INC;
      tx_tick = (tx_sum >= CLK_HZ);
      tx_load = (tx_state == TX_IDLE) && !tdre;
      tx_next = tx_state;
      tx      = 1'b1;
      case (tx_state)
         TX_IDLE:  if (tx_load) tx_next = TX_START;
         TX_START: begin
            tx = 1'b0;
            if (tx_tick) tx_next = TX_DATA;
         end
         TX_DATA:  begin
            tx = tx_shift[0];
            if (tx_tick && (tx_cnt == 3'd7)) tx_next = TX_STOP;
         end
         TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
   end

   // TX state register.
   always_ff @(posedge clk) begin
      if (rst) tx_state <= TX_IDLE;
      else     tx_state <= tx_next;
   end

   // TX datapath. A CPU write wins over the shifter load for TDRE.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_acc   <= '0;
         tx_cnt   <= '0;
         tx_shift <= '0;
         tx_hold  <= '0;
         tdre     <= 1'b1;
      end else begin
         if (tx_state == TX_IDLE) begin
            tx_acc <= '0;
            tx_cnt <= '0;
            if (tx_load) tx_shift <= tx_hold;
         end else begin
            tx_acc <= tx_tick ? (tx_sum - CLK_HZ) : tx_sum;
            if ((tx_state == TX_DATA) && tx_tick) begin
               tx_shift <= {1'b0, tx_shift[7:1]};
               tx_cnt   <= tx_cnt + 3'd1;
            end
         end
         if (wr_tdr) begin
            tx_hold <= data_in;
            tdre    <= 1'b0;
         end else if (tx_load) begin
            tdre    <= 1'b1;
         end
      end
   end

   // RX next state and baud tick; rx_done marks the mid-stop-bit sample.
   always_comb begin
      rx_sum  = rx_acc + BAUD_INC;
      rx_tick = (rx_sum >= CLK_HZ);
      rx_next = rx_state;
      rx_done = 1'b0;
      case (rx_state)
         RX_IDLE:  if (!rx_s) rx_next = RX_START;
         RX_START: if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && (rx_cnt == 3'd7)) rx_next = RX_STOP;
         RX_STOP:  if (rx_tick) begin
            rx_next = RX_IDLE;
            rx_done = 1'b1;
         end
         default:  rx_next = RX_IDLE;
      endcase
   end

   // RX state register.
   always_ff @(posedge clk) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_next;
   end

   // RX synchroniser and shifter. Half-bit preload while idle puts samples mid-bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_acc   <= '0;
         rx_cnt   <= '0;
         rx_shift <= '0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         if (rx_state == RX_IDLE) begin
            rx_acc <= CLK_HZ >> 1;
            rx_cnt <= '0;
         end else begin
            rx_acc <= rx_tick ? (rx_sum - CLK_HZ) : rx_sum;
            if ((rx_state == RX_DATA) && rx_tick) begin
               rx_shift <= {rx_s, rx_shift[7:1]};
               rx_cnt   <= rx_cnt + 3'd1;
            end
         end
      end
   end

   // Status/command/control. Clears land first, then a completing frame sets flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdrf    <= 1'b0;
         ovr     <= 1'b0;
         fe      <= 1'b0;
         rx_data <= '0;
         cmd     <= '0;
         ctrl    <= '0;
      end else begin
         if (rd_rdr) begin
            rdrf <= 1'b0;
            ovr  <= 1'b0;
            fe   <= 1'b0;
         end
         if (wr_preset) begin
            ovr  <= 1'b0;
            fe   <= 1'b0;
            cmd  <= '0;
            ctrl <= '0;
         end
         if (wr_cmd)  cmd  <= data_in;
         if (wr_ctrl) ctrl <= data_in;
         if (rx_done) begin
            fe <= !rx_s;
            if (rdrf && !rd_rdr) begin
               ovr <= 1'b1;
            end else begin
               rx_data <= rx_shift;
               rdrf    <= 1'b1;
            end
         end
      end
   end

   // Interrupt, status assembly and read mux.
   always_comb begin
      irq_pend = (cmd[1] && rdrf) || (cmd[2] && tdre);
      irq      = !irq_pend;
      status   = {irq_pend, 2'b00, tdre, rdrf, ovr, fe, 1'b0};
      case (sel)
         2'b00:   data_out = rx_data;
         2'b01:   data_out = status;
         2'b10:   data_out = cmd;
         default: data_out = ctrl;
      endcase
   end
endmodule

// File: tb/tb_uart_acia.sv
// Directed bench for uart_acia at 1 MHz / 115200 baud (bit = 8680 ns).
`timescale 1ns/1ps
module tb_uart_acia;
   localparam int BIT_NS = 8680;

   logic       clk = 1'b0;
   logic       rst, rw, rs0, rs1, cs, rx;
   logic [7:0] data_in, data_out;
   logic       tx, irq;

   int checks = 0;
   int errors = 0;

   uart_acia #(.clk_freq_hz(1_000_000), .baud_rate(115200), .oversample(16)) dut (
      .clk(clk), .rst(rst), .rw(rw), .rs0(rs0), .rs1(rs1), .cs(cs),
      .data_in(data_in), .rx(rx), .data_out(data_out), .tx(tx), .irq(irq)
   );

   // Clock: 1 MHz.
   always #500 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] sel, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; rw = 1'b0; {rs1, rs0} = sel; data_in = d;
      @(negedge clk);
      cs = 1'b0; rw = 1'b1;
   endtask

   task automatic check_read(input logic [1:0] sel, input logic [7:0] exp, input string tag);
      logic [7:0] v;
      @(negedge clk);
      cs = 1'b1; rw = 1'b1; {rs1, rs0} = sel;
      #1 v = data_out;
      @(negedge clk);
      cs = 1'b0;
      chk(tag, v, exp);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      #BIT_NS;
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #BIT_NS;
      end
      rx = stop;
      #BIT_NS;
      rx = 1'b1;
      #(2 * BIT_NS);
   endtask

   // Waits (bounded) for a start bit, then samples every bit at its nominal centre.
   task automatic tx_expect(input logic [7:0] d, input string tag);
      logic found;
      logic exp_bit;
      time  t0, tgt;
      found = 1'b0;
      t0    = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk);
         #1;
         if (tx === 1'b0) begin
            found = 1'b1;
            t0    = $time - 1;
         end
      end
      chk({tag, "_start_seen"}, {7'd0, found}, 8'd1);
      if (found) begin
         for (int j = 0; j < 10; j++) begin
            tgt = t0 + 4340 + j * BIT_NS;
            #(tgt - $time);
            exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
            chk($sformatf("%s_bit%0d", tag, j), {7'd0, tx}, {7'd0, exp_bit});
         end
      end
   endtask

   initial begin
      rst = 1'b1; cs = 1'b0; rw = 1'b1; rs0 = 1'b0; rs1 = 1'b0;
      data_in = 8'h00; rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("reset_tx", {7'd0, tx}, 8'd1);
      chk("reset_irq", {7'd0, irq}, 8'd1);
      check_read(2'b01, 8'h10, "reset_status");
      check_read(2'b10, 8'h00, "reset_cmd");
      check_read(2'b11, 8'h00, "reset_ctrl");
      check_read(2'b00, 8'h00, "reset_rxdata");

      // TX 0x55; a second byte written mid-frame waits in the holding register
      bus_write(2'b00, 8'h55);
      fork
         tx_expect(8'h55, "tx55");
         begin
            #20000;
            bus_write(2'b00, 8'hC3);
            check_read(2'b01, 8'h00, "status_hold_full");
         end
      join
      tx_expect(8'hC3, "txC3");
      #100000;
      check_read(2'b01, 8'h10, "status_tx_done");
      chk("tx_idle_high", {7'd0, tx}, 8'd1);

      // TX-empty interrupt
      bus_write(2'b10, 8'h04);
      chk("irq_tdre_on", {7'd0, irq}, 8'd0);
      check_read(2'b01, 8'h90, "status_tdre_irq");
      bus_write(2'b10, 8'h00);
      chk("irq_tdre_off", {7'd0, irq}, 8'd1);

      // RX 0xAA (TDRE remains set alongside RDRF)
      send_byte(8'hAA, 1'b1);
      check_read(2'b01, 8'h18, "status_rx_full");
      check_read(2'b00, 8'hAA, "rx_AA");
      check_read(2'b01, 8'h10, "status_rx_read");

      // Short low pulse is rejected, then a normal frame still works
      rx = 1'b0;
      #2000;
      rx = 1'b1;
      #(3 * BIT_NS);
      check_read(2'b01, 8'h10, "status_glitch");
      send_byte(8'h81, 1'b1);
      check_read(2'b01, 8'h18, "status_rx81");
      check_read(2'b00, 8'h81, "rx_81");

      // RX interrupt
      bus_write(2'b10, 8'h02);
      chk("irq_rx_idle", {7'd0, irq}, 8'd1);
      send_byte(8'h42, 1'b1);
      chk("irq_rx_on", {7'd0, irq}, 8'd0);
      check_read(2'b01, 8'h98, "status_rx_irq");
      check_read(2'b00, 8'h42, "rx_42");
      chk("irq_rx_off", {7'd0, irq}, 8'd1);

      // Overrun: second byte discarded, first kept
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      check_read(2'b01, 8'h9C, "status_overrun");
      check_read(2'b00, 8'h11, "rx_keep_first");
      check_read(2'b01, 8'h10, "status_ovr_clear");

      // Programmed reset clears cmd/ctrl/overrun but keeps RDRF and data
      bus_write(2'b11, 8'hA5);
      check_read(2'b11, 8'hA5, "ctrl_rw");
      check_read(2'b10, 8'h02, "cmd_rw");
      send_byte(8'h3C, 1'b1);
      send_byte(8'h3D, 1'b1);
      check_read(2'b01, 8'h9C, "status_overrun2");
      bus_write(2'b01, 8'h77);
      check_read(2'b10, 8'h00, "preset_cmd");
      check_read(2'b11, 8'h00, "preset_ctrl");
      check_read(2'b01, 8'h18, "preset_status");
      check_read(2'b00, 8'h3C, "preset_rxdata");
      check_read(2'b01, 8'h10, "status_after_read");

      // Framing error
      send_byte(8'h5A, 1'b0);
      check_read(2'b01, 8'h1A, "status_framing");
      check_read(2'b00, 8'h5A, "rx_5A");
      check_read(2'b01, 8'h10, "status_fe_clear");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
